// File: rtl/sd_clock_ctrl.sv
// sd_clock_ctrl: SD card clock divider and sequencer.
// SD_CLK is divided from CLK and toggled only at phase boundaries. A stop
// (STOP_REQ, divider change or idle gating) is taken only after a complete
// low phase, so the card never sees a runt high or low phase.
// Optional macro SD_CLK_AUTOGATE_EN: gate SD_CLK after IDLE_CYCLES idle
// SD_CLK periods, and restart it when BUSY rises.
module sd_clock_ctrl #(
    parameter int               DIV_W       = 8,
    parameter logic [DIV_W-1:0] DEF_DIV     = DIV_W'(8'hFF),
    parameter int               IDLE_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DIV_REQ,
    input  logic [DIV_W-1:0] DIV_VAL,
    output logic             DIV_ACK,
    input  logic             STOP_REQ,
    input  logic             BUSY,
    output logic             SD_CLK,
    output logic             SD_CLK_RISE,
    output logic             SD_CLK_FALL,
    output logic             CLK_RUNNING,
    output logic [DIV_W-1:0] CUR_DIV
);

    typedef enum logic {RUN = 1'b0, STOPPED = 1'b1} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             sd_clk, sd_clk_n;
    logic             rise, rise_n;
    logic             fall, fall_n;
    logic             ack, ack_n;
    // Set once a request has been acked; cleared only when DIV_REQ drops, so
    // a request held past its ack is never acked a second time.
    logic             ack_done, ack_done_n;
    logic             gate_req;
    logic             stop_pending;

`ifdef SD_CLK_AUTOGATE_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    // Gate only while still idle; BUSY high drops the request at once
    assign gate_req = (idle_cnt == IW'(IDLE_CYCLES)) && !BUSY;

    // Count SD_CLK falls while idle, saturating; any activity restarts the count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            idle_cnt <= '0;
        else if (BUSY)
            idle_cnt <= '0;
        else if (fall && idle_cnt != IW'(IDLE_CYCLES))
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_busy;
    assign gate_req    = 1'b0;
    assign unused_busy = BUSY ^ (IDLE_CYCLES == 0);
`endif

    assign stop_pending = STOP_REQ | DIV_REQ | gate_req;

    // Next-state, divider counter, clock and strobe generation
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_q;
        sd_clk_n   = sd_clk;
        rise_n     = 1'b0;
        fall_n     = 1'b0;
        ack_n      = 1'b0;
        ack_done_n = ack_done;
        case (state)
            RUN: begin
                if (cnt != div_q) begin
                    cnt_n = cnt + 1'b1;
                end else if (sd_clk) begin
                    sd_clk_n = 1'b0;
                    cnt_n    = '0;
                    fall_n   = 1'b1;
                end else if (!stop_pending) begin
                    sd_clk_n = 1'b1;
                    cnt_n    = '0;
                    rise_n   = 1'b1;
                end else begin
                    // Low phase complete: park low instead of rising
                    cnt_n   = '0;
                    state_n = STOPPED;
                end
            end
            STOPPED: begin
                sd_clk_n = 1'b0;
                cnt_n    = '0;
                if (DIV_REQ && !ack && !ack_done) begin
                    div_n      = DIV_VAL;
                    ack_n      = 1'b1;
                    ack_done_n = 1'b1;
                end
                if (!STOP_REQ && !DIV_REQ && !ack && !gate_req) begin
                    // Restart straight into a full high phase
                    sd_clk_n = 1'b1;
                    rise_n   = 1'b1;
                    state_n  = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        if (!DIV_REQ)
            ack_done_n = 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= RUN;
            cnt      <= '0;
            div_q    <= DEF_DIV;
            sd_clk   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            ack      <= 1'b0;
            ack_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_q    <= div_n;
            sd_clk   <= sd_clk_n;
            rise     <= rise_n;
            fall     <= fall_n;
            ack      <= ack_n;
            ack_done <= ack_done_n;
        end
    end

    assign SD_CLK      = sd_clk;
    assign SD_CLK_RISE = rise;
    assign SD_CLK_FALL = fall;
    assign DIV_ACK     = ack;
    assign CLK_RUNNING = (state == RUN);
    assign CUR_DIV     = div_q;

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// tb_sd_clock_ctrl: directed bench for sd_clock_ctrl with an expected-value
// queue; expectations are pushed with the stimulus and popped on observation.
module tb_sd_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       div_req;
    logic [7:0] div_val;
    logic       div_ack;
    logic       stop_req;
    logic       busy;
    logic       sd_clk;
    logic       sd_rise;
    logic       sd_fall;
    logic       clk_running;
    logic [7:0] cur_div;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    sd_clock_ctrl #(.DIV_W(8), .DEF_DIV(8'hFF), .IDLE_CYCLES(8)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .DIV_REQ     (div_req),
        .DIV_VAL     (div_val),
        .DIV_ACK     (div_ack),
        .STOP_REQ    (stop_req),
        .BUSY        (busy),
        .SD_CLK      (sd_clk),
        .SD_CLK_RISE (sd_rise),
        .SD_CLK_FALL (sd_fall),
        .CLK_RUNNING (clk_running),
        .CUR_DIV     (cur_div)
    );

    always #5 clk = ~clk;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one CLK cycle; outputs are sampled 1 time unit after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (sd_rise) break;
        end
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (!div_ack && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Called in a RISE cycle; measures up to the next RISE
    task automatic measure(output int per, output int hi, output int nf);
        per = 0; hi = 0; nf = 0;
        do begin
            hi += int'(sd_clk);
            tick();
            per++;
            nf += int'(sd_fall);
        end while (!sd_rise && per < 2000);
    endtask

    initial begin
        int n, per, hi, nf, lowrun, bad, acks, falls;
        rst_n = 1'b0; div_req = 1'b0; div_val = 8'h00; stop_req = 1'b0; busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        sb_push("rst_sd_clk", 0);    sb_check(32'(sd_clk));
        sb_push("rst_ack", 0);       sb_check(32'(div_ack));
        sb_push("rst_running", 1);   sb_check(32'(clk_running));
        sb_push("rst_cur_div", 255); sb_check(32'(cur_div));
        sb_push("rst_strobes", 0);   sb_check(32'({sd_rise, sd_fall}));
        rst_n = 1'b1;

        // 1: default divider, period 512, 50% duty, one fall per period
        sb_push("t1_first_rise", 256);
        wait_rise(1000, n); sb_check(32'(n));
        sb_push("t1_period", 512); sb_push("t1_high", 256); sb_push("t1_falls", 1);
        measure(per, hi, nf);
        sb_check(32'(per)); sb_check(32'(hi)); sb_check(32'(nf));
        sb_push("t1_cur_div", 255); sb_check(32'(cur_div));

        // 2: request DIV_VAL=1 at cnt=10 of the high phase
        repeat (10) tick();
        div_req = 1'b1; div_val = 8'd1;
        sb_push("t2_ack_lat", 503); sb_push("t2_last_low", 256);
        n = 0; lowrun = 0;
        while (!div_ack && n < 600) begin
            tick();
            n++;
            lowrun += int'(!sd_clk && clk_running);
        end
        sb_check(32'(n)); sb_check(32'(lowrun));
        sb_push("t2_cur_div", 1);     sb_check(32'(cur_div));
        sb_push("t2_ack_running", 0); sb_check(32'(clk_running));
        div_req = 1'b0;
        sb_push("t2_restart", 2);
        wait_rise(20, n); sb_check(32'(n));
        sb_push("t2_period", 4); sb_push("t2_high", 2);
        measure(per, hi, nf); sb_check(32'(per)); sb_check(32'(hi));

        // 3: DIV_VAL=0 gives CLK/2, then a 10-cycle STOP_REQ hold
        div_req = 1'b1; div_val = 8'd0;
        sb_push("t3_ack_lat", 5);
        wait_ack(20, n); sb_check(32'(n));
        div_req = 1'b0;
        sb_push("t3_restart", 2);
        wait_rise(20, n); sb_check(32'(n));
        sb_push("t3_period", 2); sb_push("t3_high", 1);
        measure(per, hi, nf); sb_check(32'(per)); sb_check(32'(hi));
        stop_req = 1'b1;
        tick(); tick();
        bad = 0;
        repeat (10) begin
            bad += int'(sd_clk | clk_running | sd_rise | sd_fall);
            tick();
        end
        sb_push("t3_stop_bad", 0); sb_check(32'(bad));
        stop_req = 1'b0;
        tick();
        sb_push("t3_restart_clk", 1);  sb_check(32'(sd_clk));
        sb_push("t3_restart_rise", 1); sb_check(32'(sd_rise));

        // 4: DIV_REQ with STOP_REQ, request held one cycle past the ack
        div_req = 1'b1; stop_req = 1'b1; div_val = 8'd3;
        sb_push("t4_ack_lat", 3);
        wait_ack(20, n); sb_check(32'(n));
        acks = 0; bad = 0;
        tick(); acks += int'(div_ack);
        tick(); acks += int'(div_ack);
        div_req = 1'b0;
        repeat (20) begin
            tick();
            acks += int'(div_ack);
            bad  += int'(sd_clk | clk_running);
        end
        sb_push("t4_extra_acks", 0); sb_check(32'(acks));
        sb_push("t4_held_bad", 0);   sb_check(32'(bad));
        sb_push("t4_cur_div", 3);    sb_check(32'(cur_div));
        stop_req = 1'b0;
        tick();
        sb_push("t4_restart_rise", 1); sb_check(32'(sd_rise));
        sb_push("t4_period", 8); sb_push("t4_high", 4);
        measure(per, hi, nf); sb_check(32'(per)); sb_check(32'(hi));

        // 5: asynchronous reset mid high phase with a request pending
        tick();
        div_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        sb_push("t5_sd_clk", 0);    sb_check(32'(sd_clk));
        sb_push("t5_ack", 0);       sb_check(32'(div_ack));
        sb_push("t5_cur_div", 255); sb_check(32'(cur_div));
        sb_push("t5_running", 1);   sb_check(32'(clk_running));
        div_req = 1'b0;
        #2 rst_n = 1'b1;
        sb_push("t5_first_rise", 256);
        wait_rise(1000, n); sb_check(32'(n));
        sb_push("t5_cur_div_after", 255); sb_check(32'(cur_div));

`ifdef SD_CLK_AUTOGATE_EN
        // 6: idle gating after 8 falls, restart on BUSY
        div_req = 1'b1; div_val = 8'd1;
        wait_ack(1000, n);
        sb_push("t6_ack", 1); sb_check(32'(div_ack));
        div_req = 1'b0;
        wait_rise(20, n);
        busy = 1'b0;
        falls = 0;
        repeat (100) begin
            tick();
            falls += int'(sd_fall);
        end
        sb_push("t6_falls", 8);      sb_check(32'(falls));
        sb_push("t6_gated_clk", 0);  sb_check(32'(sd_clk));
        sb_push("t6_gated_run", 0);  sb_check(32'(clk_running));
        busy = 1'b1;
        tick();
        sb_push("t6_restart_rise", 1); sb_check(32'(sd_rise));
        sb_push("t6_restart_clk", 1);  sb_check(32'(sd_clk));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
